csr_ctrl: RTL and testbench

- Machine-mode CSR control stage sitting directly upstream of the CSR register file; the only writer of that file.
- Executes Zicsr instructions (read-modify-write) from the execute stage, sequences trap entry (exceptions and interrupts) and MRET.
- Produces redirect and flush requests to the fetch/pipeline control.
- Drives the file's single read port and single write port.

---
 rtl/csr_pkg.sv | 52 +++++
 rtl/csr_ctrl_if.sv | 56 +++++
 rtl/csr_addr_decode.sv | 26 ++
 rtl/csr_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_csr_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR control stage: addresses, file
// indices, Zicsr encodings, cause codes, mstatus layout and the FSM states.
package csr_pkg;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MTVAL   = 12'h343;

  localparam logic [2:0] IDX_MSTATUS = 3'd0;
  localparam logic [2:0] IDX_MIE     = 3'd1;
  localparam logic [2:0] IDX_MTVEC   = 3'd2;
  localparam logic [2:0] IDX_MEPC    = 3'd3;
  localparam logic [2:0] IDX_MCAUSE  = 3'd4;
  localparam logic [2:0] IDX_MTVAL   = 3'd5;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  localparam logic [3:0] CAUSE_M_EXT   = 4'd11;
  localparam logic [3:0] CAUSE_M_TIMER = 4'd7;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;

  // Only MIE/MPIE are writable; MPP is hard-wired to machine mode.
  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_FORCE = 32'h0000_1800;

  typedef enum logic [2:0] {
    IDLE,
    CSR,
    T_EPC,
    T_CAUSE,
    T_TVAL,
    T_STATUS,
    M_RET
  } csr_state_e;

endpackage

// File: rtl/csr_ctrl_if.sv
// Pipeline-side and register-file-side signals of the CSR control stage.
// Handshake: a request is taken on a rising clk edge where req_valid and
// req_ready are both 1; events are taken where evt_ack is 1.
interface csr_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 3
);
  import csr_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_funct3;
  logic [11:0]      req_csr;
  logic [XLEN-1:0]  req_src;
  logic             req_src_zero;
  logic             rsp_valid;
  logic [XLEN-1:0]  rsp_rdata;
  logic             rsp_illegal;
  logic             exc_valid;
  logic [3:0]       exc_cause;
  logic [XLEN-1:0]  exc_tval;
  logic [XLEN-1:0]  trap_pc;
  logic             irq_ext;
  logic             irq_timer;
  logic             mret_valid;
  logic             evt_ack;
  logic [IDX_W-1:0] csr_raddr;
  logic [XLEN-1:0]  csr_rdata;
  logic             csr_we;
  logic [IDX_W-1:0] csr_waddr;
  logic [XLEN-1:0]  csr_wdata;
  logic             flush;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             busy;
  csr_state_e       state;

  modport slave (
    input  req_valid, req_funct3, req_csr, req_src, req_src_zero,
    input  exc_valid, exc_cause, exc_tval, trap_pc, irq_ext, irq_timer, mret_valid,
    input  csr_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_illegal, evt_ack,
    output csr_raddr, csr_we, csr_waddr, csr_wdata,
    output flush, redirect_valid, redirect_pc, busy, state
  );

  modport master (
    output req_valid, req_funct3, req_csr, req_src, req_src_zero,
    output exc_valid, exc_cause, exc_tval, trap_pc, irq_ext, irq_timer, mret_valid,
    output csr_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_illegal, evt_ack,
    input  csr_raddr, csr_we, csr_waddr, csr_wdata,
    input  flush, redirect_valid, redirect_pc, busy, state
  );

endinterface

// File: rtl/csr_addr_decode.sv
// Maps a 12-bit machine CSR address onto the local register-file index.
module csr_addr_decode
  import csr_pkg::*;
#(
  parameter int IDX_W = 3
) (
  input  logic [11:0]      i_addr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_legal
);

  always_comb begin
    o_idx   = '0;
    o_legal = 1'b1;
    case (i_addr)
      ADDR_MSTATUS: o_idx = IDX_W'(IDX_MSTATUS);
      ADDR_MIE:     o_idx = IDX_W'(IDX_MIE);
      ADDR_MTVEC:   o_idx = IDX_W'(IDX_MTVEC);
      ADDR_MEPC:    o_idx = IDX_W'(IDX_MEPC);
      ADDR_MCAUSE:  o_idx = IDX_W'(IDX_MCAUSE);
      ADDR_MTVAL:   o_idx = IDX_W'(IDX_MTVAL);
      default:      o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/csr_ctrl.sv
// Machine-mode CSR control: Zicsr read-modify-write, trap entry and MRET,
// sole writer of the CSR register file.
module csr_ctrl
  import csr_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int IDX_W = 3
) (
  input logic       clk,
  input logic       rst,
  csr_ctrl_if.slave bus
);

  csr_state_e       r_state, w_next;
  logic [IDX_W-1:0] r_idx;
  logic             r_illegal;
  logic [1:0]       r_op;
  logic [XLEN-1:0]  r_src;
  logic             r_src_zero;
  logic [3:0]       r_code;
  logic             r_irq;
  logic [XLEN-1:0]  r_tval, r_pc, r_mstatus, r_mie;

  logic [IDX_W-1:0] w_dec_idx, w_waddr;
  logic             w_dec_legal, w_op_ok, w_idle, w_irq_ext, w_irq_tmr, w_irq_take;
  logic             w_acc_exc, w_acc_irq, w_acc_req;
  logic [1:0]       w_op;
  logic [XLEN-1:0]  w_new, w_wraw, w_status_trap, w_status_mret, w_vec_off;

  csr_addr_decode #(.IDX_W(IDX_W)) u_dec (
    .i_addr (bus.req_csr),
    .o_idx  (w_dec_idx),
    .o_legal(w_dec_legal)
  );

  function automatic logic [XLEN-1:0] wmask(input logic [IDX_W-1:0] idx, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] m;
    m = d;
    if (idx == IDX_W'(IDX_MSTATUS)) m = (d & XLEN'(MSTATUS_WMASK)) | XLEN'(MSTATUS_FORCE);
    else if (idx == IDX_W'(IDX_MTVEC)) m[1] = 1'b0;
    else if (idx == IDX_W'(IDX_MEPC)) m[0] = 1'b0;
    return m;
  endfunction

  always_comb begin
    w_op    = OP_RW;
    w_op_ok = 1'b1;
    case (bus.req_funct3)
      F3_CSRRW, F3_CSRRWI: w_op = OP_RW;
      F3_CSRRS, F3_CSRRSI: w_op = OP_RS;
      F3_CSRRC, F3_CSRRCI: w_op = OP_RC;
      default:             w_op_ok = 1'b0;
    endcase
  end

  assign w_idle     = (r_state == IDLE);
  assign w_irq_ext  = bus.irq_ext & r_mie[MIE_MEIE];
  assign w_irq_tmr  = bus.irq_timer & r_mie[MIE_MTIE];
  assign w_irq_take = r_mstatus[MSTATUS_MIE] & (w_irq_ext | w_irq_tmr);
  assign w_acc_exc  = w_idle & bus.exc_valid;
  assign w_acc_irq  = w_idle & ~bus.exc_valid & w_irq_take;
  assign w_acc_req  = w_idle & ~bus.exc_valid & ~w_irq_take & ~bus.mret_valid & bus.req_valid;

  assign w_status_trap = XLEN'(MSTATUS_FORCE) | (XLEN'(r_mstatus[MSTATUS_MIE]) << MSTATUS_MPIE);
  assign w_status_mret = XLEN'(MSTATUS_FORCE) | (XLEN'(1'b1) << MSTATUS_MPIE)
                       | (XLEN'(r_mstatus[MSTATUS_MPIE]) << MSTATUS_MIE);
  // Vectored mode only offsets interrupts; the add wraps at XLEN bits.
  assign w_vec_off = (bus.csr_rdata[0] & r_irq) ? XLEN'({r_code, 2'b00}) : '0;

  // Read index depends only on state so the file's combinational read never loops back.
  assign bus.csr_raddr = (r_state == CSR)      ? r_idx :
                         (r_state == T_STATUS) ? IDX_W'(IDX_MTVEC) :
                         (r_state == M_RET)    ? IDX_W'(IDX_MEPC) : '0;

  always_comb begin
    w_new = bus.csr_rdata;
    case (r_op)
      OP_RS:   w_new = bus.csr_rdata | r_src;
      OP_RC:   w_new = bus.csr_rdata & ~r_src;
      default: w_new = r_src;
    endcase
  end

  always_comb begin
    w_next             = r_state;
    bus.req_ready      = 1'b0;
    bus.evt_ack        = 1'b0;
    bus.rsp_valid      = 1'b0;
    bus.rsp_rdata      = '0;
    bus.rsp_illegal    = 1'b0;
    bus.csr_we         = 1'b0;
    bus.flush          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    w_waddr            = '0;
    w_wraw             = '0;
    unique case (r_state)
      IDLE: begin
        bus.req_ready = ~bus.exc_valid & ~w_irq_take & ~bus.mret_valid;
        bus.evt_ack   = bus.exc_valid | w_irq_take | bus.mret_valid;
        if (bus.exc_valid | w_irq_take) w_next = T_EPC;
        else if (bus.mret_valid)        w_next = M_RET;
        else if (bus.req_valid)         w_next = CSR;
      end
      CSR: begin
        bus.rsp_valid = 1'b1;
        w_next        = IDLE;
        if (r_illegal) begin
          bus.rsp_illegal = 1'b1;
        end else begin
          bus.rsp_rdata = bus.csr_rdata;
          bus.csr_we    = ~(r_src_zero & (r_op != OP_RW));
          w_waddr       = r_idx;
          w_wraw        = w_new;
        end
      end
      T_EPC: begin
        bus.csr_we = 1'b1;
        bus.flush  = 1'b1;
        w_waddr    = IDX_W'(IDX_MEPC);
        w_wraw     = r_pc;
        w_next     = T_CAUSE;
      end
      T_CAUSE: begin
        bus.csr_we       = 1'b1;
        w_waddr          = IDX_W'(IDX_MCAUSE);
        w_wraw           = XLEN'(r_code);
        w_wraw[XLEN-1]   = r_irq;
        w_next           = T_TVAL;
      end
      T_TVAL: begin
        bus.csr_we = 1'b1;
        w_waddr    = IDX_W'(IDX_MTVAL);
        w_wraw     = r_tval;
        w_next     = T_STATUS;
      end
      T_STATUS: begin
        bus.csr_we         = 1'b1;
        w_waddr            = IDX_W'(IDX_MSTATUS);
        w_wraw             = w_status_trap;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = {bus.csr_rdata[XLEN-1:2], 2'b00} + w_vec_off;
        w_next             = IDLE;
      end
      M_RET: begin
        bus.csr_we         = 1'b1;
        bus.flush          = 1'b1;
        w_waddr            = IDX_W'(IDX_MSTATUS);
        w_wraw             = w_status_mret;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = bus.csr_rdata;
        w_next             = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign bus.csr_waddr = w_waddr;
  assign bus.csr_wdata = bus.csr_we ? wmask(w_waddr, w_wraw) : '0;
  assign bus.busy      = ~w_idle;
  assign bus.state     = r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_illegal  <= 1'b0;
      r_op       <= OP_RW;
      r_src      <= '0;
      r_src_zero <= 1'b0;
      r_code     <= '0;
      r_irq      <= 1'b0;
      r_tval     <= '0;
      r_pc       <= '0;
      r_mstatus  <= XLEN'(MSTATUS_FORCE);
      r_mie      <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc_req) begin
        r_idx      <= w_dec_idx;
        r_illegal  <= ~w_dec_legal | ~w_op_ok;
        r_op       <= w_op;
        r_src      <= bus.req_src;
        r_src_zero <= bus.req_src_zero;
      end
      if (w_acc_exc) begin
        r_code <= bus.exc_cause;
        r_tval <= bus.exc_tval;
        r_pc   <= bus.trap_pc;
        r_irq  <= 1'b0;
      end else if (w_acc_irq) begin
        r_code <= w_irq_ext ? CAUSE_M_EXT : CAUSE_M_TIMER;
        r_tval <= '0;
        r_pc   <= bus.trap_pc;
        r_irq  <= 1'b1;
      end
      if (bus.csr_we && bus.csr_waddr == IDX_W'(IDX_MSTATUS)) r_mstatus <= bus.csr_wdata;
      if (bus.csr_we && bus.csr_waddr == IDX_W'(IDX_MIE))     r_mie     <= bus.csr_wdata;
    end
  end

endmodule

// File: tb/tb_csr_ctrl.sv
// Bench for csr_ctrl: models the CSR file, drives a vector table of Zicsr ops
// and hand-written trap/MRET/reset sequences, and checks every file write.
module tb_csr_ctrl;

  localparam int XLEN  = 32;
  localparam int IDX_W = 3;
  localparam int W     = IDX_W + XLEN;

  typedef struct {
    logic [2:0]       f3;
    logic [11:0]      csr;
    logic [XLEN-1:0]  src;
    logic             sz;
    logic             ill;
    logic [XLEN-1:0]  rdata;
    logic             we;
    logic [IDX_W-1:0] idx;
    logic [XLEN-1:0]  wdata;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad   = 0;
  logic [W-1:0]    exp_q[$];
  logic [XLEN-1:0] file_q[0:7];
  vec_t            vecs[13];

  csr_ctrl_if #(.XLEN(XLEN), .IDX_W(IDX_W)) bus();
  csr_ctrl #(.XLEN(XLEN), .IDX_W(IDX_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  // CSR register file model: combinational read, clocked write
  assign bus.csr_rdata = file_q[bus.csr_raddr];
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) file_q[i] <= '0;
    end else if (bus.csr_we) begin
      file_q[bus.csr_waddr] <= bus.csr_wdata;
    end
  end

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // advance to the next falling edge and score any file write seen there
  task automatic tick();
    logic [W-1:0] e;
    @(negedge clk);
    if (bus.csr_we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got idx=%0d data=%h want none", bus.csr_waddr, bus.csr_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({bus.csr_waddr, bus.csr_wdata} !== e) begin
          bad++;
          $display("FAIL write: got idx=%0d data=%h want idx=%0d data=%h",
                   bus.csr_waddr, bus.csr_wdata, e[W-1:XLEN], e[XLEN-1:0]);
        end
      end
    end
  endtask

  task automatic push_wr(input logic [IDX_W-1:0] idx, input logic [XLEN-1:0] d);
    exp_q.push_back({idx, d});
  endtask

  task automatic do_req(input string name, input vec_t v);
    tick();
    bus.req_valid    = 1'b1;
    bus.req_funct3   = v.f3;
    bus.req_csr      = v.csr;
    bus.req_src      = v.src;
    bus.req_src_zero = v.sz;
    #1;
    chk({name, "_ready"}, XLEN'(bus.req_ready), 1);
    if (v.we) push_wr(v.idx, v.wdata);
    tick();
    chk({name, "_rsp_valid"}, XLEN'(bus.rsp_valid), 1);
    chk({name, "_illegal"}, XLEN'(bus.rsp_illegal), XLEN'(v.ill));
    chk({name, "_rdata"}, bus.rsp_rdata, v.rdata);
    bus.req_valid = 1'b0;
  endtask

  task automatic simple_req(input string name, input logic [2:0] f3, input logic [11:0] a,
                            input logic [XLEN-1:0] src, input logic [XLEN-1:0] rd,
                            input logic [IDX_W-1:0] idx, input logic [XLEN-1:0] wd);
    vec_t v;
    v = '{f3, a, src, 1'b0, 1'b0, rd, 1'b1, idx, wd};
    do_req(name, v);
  endtask

  initial begin
    bus.req_valid = 0; bus.req_funct3 = 0; bus.req_csr = 0; bus.req_src = 0; bus.req_src_zero = 0;
    bus.exc_valid = 0; bus.exc_cause = 0; bus.exc_tval = 0; bus.trap_pc = 0;
    bus.irq_ext = 0; bus.irq_timer = 0; bus.mret_valid = 0;

    //              f3      csr      src           sz ill rdata         we idx wdata
    vecs[0]  = '{3'b001, 12'h305, 32'h8000_0101, 0, 0, 32'h0,         1, 2, 32'h8000_0101};
    vecs[1]  = '{3'b010, 12'h300, 32'h0000_0008, 0, 0, 32'h0,         1, 0, 32'h0000_1808};
    vecs[2]  = '{3'b010, 12'h304, 32'h0000_0800, 0, 0, 32'h0,         1, 1, 32'h0000_0800};
    vecs[3]  = '{3'b101, 12'h341, 32'h0000_0205, 0, 0, 32'h0,         1, 3, 32'h0000_0204};
    vecs[4]  = '{3'b010, 12'h341, 32'h0,         1, 0, 32'h0000_0204, 0, 0, 32'h0};
    vecs[5]  = '{3'b001, 12'h7C0, 32'h0000_1234, 0, 1, 32'h0,         0, 0, 32'h0};
    vecs[6]  = '{3'b000, 12'h300, 32'h0000_0008, 0, 1, 32'h0,         0, 0, 32'h0};
    vecs[7]  = '{3'b001, 12'h343, 32'hFFFF_0000, 0, 0, 32'h0,         1, 5, 32'hFFFF_0000};
    vecs[8]  = '{3'b111, 12'h343, 32'h0F0F_0000, 0, 0, 32'hFFFF_0000, 1, 5, 32'hF0F0_0000};
    vecs[9]  = '{3'b110, 12'h305, 32'h0000_0002, 0, 0, 32'h8000_0101, 1, 2, 32'h8000_0101};
    vecs[10] = '{3'b001, 12'h300, 32'hFFFF_FFFF, 0, 0, 32'h0000_1808, 1, 0, 32'h0000_1888};
    vecs[11] = '{3'b011, 12'h342, 32'h0,         1, 0, 32'h0,         0, 0, 32'h0};
    vecs[12] = '{3'b100, 12'h304, 32'h0000_0001, 0, 1, 32'h0,         0, 0, 32'h0};

    // reset state
    repeat (3) tick();
    chk("rst_csr_we", XLEN'(bus.csr_we), 0);
    chk("rst_rsp_valid", XLEN'(bus.rsp_valid), 0);
    chk("rst_busy", XLEN'(bus.busy), 0);
    chk("rst_req_ready", XLEN'(bus.req_ready), 1);
    chk("rst_redirect", XLEN'(bus.redirect_valid), 0);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) do_req($sformatf("vec%0d", i), vecs[i]);

    // external interrupt with vectored mtvec
    tick();
    bus.trap_pc = 32'h100;
    bus.irq_ext = 1'b1;
    #1;
    chk("irq_ack", XLEN'(bus.evt_ack), 1);
    chk("irq_req_ready", XLEN'(bus.req_ready), 0);
    push_wr(3, 32'h100); push_wr(4, 32'h8000_000B); push_wr(0, 0); push_wr(0, 32'h1880);
    void'(exp_q.pop_back()); void'(exp_q.pop_back());
    push_wr(5, 32'h0); push_wr(0, 32'h1880);
    tick();
    chk("irq_flush_epc", XLEN'(bus.flush), 1);
    tick();
    chk("irq_flush_cause", XLEN'(bus.flush), 0);
    tick();
    chk("irq_no_redirect_early", XLEN'(bus.redirect_valid), 0);
    tick();
    chk("irq_redirect_valid", XLEN'(bus.redirect_valid), 1);
    chk("irq_redirect_pc", bus.redirect_pc, 32'h8000_012C);
    tick();
    chk("irq_masked_after_trap", XLEN'(bus.evt_ack), 0);
    chk("irq_busy_after", XLEN'(bus.busy), 0);
    bus.irq_ext = 1'b0;

    // exception beats a same-cycle request; no vectoring for exceptions
    tick();
    bus.exc_valid = 1'b1; bus.exc_cause = 4'd2; bus.exc_tval = 32'hDEAD_BEEF; bus.trap_pc = 32'h300;
    bus.req_valid = 1'b1; bus.req_funct3 = 3'b001; bus.req_csr = 12'h300; bus.req_src = 32'h0;
    #1;
    chk("exc_req_ready", XLEN'(bus.req_ready), 0);
    chk("exc_ack", XLEN'(bus.evt_ack), 1);
    push_wr(3, 32'h300); push_wr(4, 32'h2); push_wr(5, 32'hDEAD_BEEF); push_wr(0, 32'h1800);
    tick();
    bus.exc_valid = 1'b0; bus.req_valid = 1'b0;
    chk("exc_rsp_valid", XLEN'(bus.rsp_valid), 0);
    tick(); tick(); tick();
    chk("exc_redirect_valid", XLEN'(bus.redirect_valid), 1);
    chk("exc_redirect_pc", bus.redirect_pc, 32'h8000_0100);

    // MRET restores MIE from MPIE
    simple_req("set_mstatus", 3'b001, 12'h300, 32'h80, 32'h1800, 0, 32'h1880);
    simple_req("set_mepc", 3'b001, 12'h341, 32'h204, 32'h300, 3, 32'h204);
    tick();
    bus.mret_valid = 1'b1;
    #1;
    chk("mret_ack", XLEN'(bus.evt_ack), 1);
    push_wr(0, 32'h1888);
    tick();
    chk("mret_redirect_valid", XLEN'(bus.redirect_valid), 1);
    chk("mret_redirect_pc", bus.redirect_pc, 32'h204);
    chk("mret_flush", XLEN'(bus.flush), 1);
    bus.mret_valid = 1'b0;
    tick();
    chk("mret_busy_after", XLEN'(bus.busy), 0);

    // timer interrupt, vectored offset 4*7
    simple_req("set_mtie", 3'b010, 12'h304, 32'h80, 32'h800, 1, 32'h880);
    tick();
    bus.irq_timer = 1'b1; bus.trap_pc = 32'h401;
    #1;
    chk("tmr_ack", XLEN'(bus.evt_ack), 1);
    push_wr(3, 32'h400); push_wr(4, 32'h8000_0007); push_wr(5, 32'h0); push_wr(0, 32'h1880);
    tick(); tick(); tick(); tick();
    chk("tmr_redirect_pc", bus.redirect_pc, 32'h8000_011C);
    bus.irq_timer = 1'b0;

    // reset in the middle of T_CAUSE abandons the trap
    tick();
    bus.exc_valid = 1'b1; bus.exc_cause = 4'd5; bus.exc_tval = 32'h1; bus.trap_pc = 32'h500;
    push_wr(3, 32'h500);
    tick();
    bus.exc_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    tick();
    chk("midrst_csr_we", XLEN'(bus.csr_we), 0);
    chk("midrst_redirect", XLEN'(bus.redirect_valid), 0);
    chk("midrst_busy", XLEN'(bus.busy), 0);
    chk("midrst_req_ready", XLEN'(bus.req_ready), 1);
    tick();
    rst = 1'b1;
    repeat (6) tick();
    chk("post_rst_busy", XLEN'(bus.busy), 0);
    chk("post_rst_req_ready", XLEN'(bus.req_ready), 1);
    chk("exp_q_empty", XLEN'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
